// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one parallel-to-serial
// shifter: one LOAD cycle, 9 SHIFT cycles, then STOP_BITS idle-high GAP cycles.
module serial_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int STOP_BITS = 1
) (
  input  logic                   dataClk,
  input  logic                   rstN,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   reqData,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic                   txLoad,
  output logic [7:0]             txData,
  output logic                   busy
);

  localparam int         PW         = $clog2(NUM_REQ);
  localparam logic [3:0] SHIFT_LAST = 4'd8;
  localparam logic [3:0] GAP_LAST   = 4'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t               state_q;
  logic [PW-1:0]        ptr_q;
  logic [3:0]           cnt_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   done_q;
  logic                 txLoad_q;
  logic                 busy_q;
  logic [7:0]           txData_q;

  logic                 hi_found;
  logic                 lo_found;
  logic [PW-1:0]        hi_idx;
  logic [PW-1:0]        lo_idx;
  logic [PW-1:0]        win_d;
  logic [PW-1:0]        ptr_d;
  logic [NUM_REQ-1:0]   grant_d;
  logic [7:0]           data_d;

  // Round-robin: first set bit at or above the pointer, else lowest set bit.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hi_found && req[i] && (PW'(i) >= ptr_q)) begin
        hi_found = 1'b1;
        hi_idx   = PW'(i);
      end
      if (!lo_found && req[i]) begin
        lo_found = 1'b1;
        lo_idx   = PW'(i);
      end
    end
    win_d   = hi_found ? hi_idx : lo_idx;
    ptr_d   = (win_d == PW'(NUM_REQ - 1)) ? '0 : win_d + 1'b1;
    grant_d = '0;
    data_d  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_d == PW'(i)) begin
        grant_d[i] = 1'b1;
        data_d     = reqData[8*i +: 8];
      end
    end
  end

  always_ff @(posedge dataClk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      txLoad_q <= 1'b0;
      txData_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q  <= LOAD;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            txData_q <= data_d;
            txLoad_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        LOAD: begin
          state_q  <= SHIFT;
          txLoad_q <= 1'b0;
          cnt_q    <= '0;
        end
        SHIFT: begin
          if (cnt_q == SHIFT_LAST) begin
            state_q <= GAP;
            cnt_q   <= '0;
            done_q  <= (STOP_BITS == 1) ? grant_q : '0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + 4'd1;
            // done is registered, so it is raised on entry to the last gap cycle
            done_q <= ((cnt_q + 4'd1) == GAP_LAST) ? grant_q : '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant  = grant_q;
  assign done   = done_q;
  assign txLoad = txLoad_q;
  assign txData = txData_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter: one instance with STOP_BITS=1 and one
// with STOP_BITS=3 share the same stimulus.
module tb_serial_tx_arbiter;

  logic        dataClk = 1'b0;
  logic        rstN    = 1'b0;
  logic [3:0]  req     = '0;
  logic [31:0] reqData = '0;

  logic [3:0]  grant, done, grant3, done3;
  logic        txLoad, busy, txLoad3, busy3;
  logic [7:0]  txData, txData3;

  int checks   = 0;
  int failures = 0;

  serial_tx_arbiter #(.NUM_REQ(4), .STOP_BITS(1)) dut (
    .dataClk(dataClk), .rstN(rstN), .req(req), .reqData(reqData),
    .grant(grant), .done(done), .txLoad(txLoad), .txData(txData), .busy(busy)
  );

  serial_tx_arbiter #(.NUM_REQ(4), .STOP_BITS(3)) dut3 (
    .dataClk(dataClk), .rstN(rstN), .req(req), .reqData(reqData),
    .grant(grant3), .done(done3), .txLoad(txLoad3), .txData(txData3), .busy(busy3)
  );

  always #5 dataClk = ~dataClk;

  task automatic tick();
    @(posedge dataClk);
    #1;
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    rstN = 1'b0; req = 4'hF; reqData = 32'hFFFF_FFFF;
    #1;
    checks++;
    if ({grant, done, txLoad, txData, busy} !== 18'h0) begin
      failures++;
      $display("FAIL reset_outputs act=%h exp=0", {grant, done, txLoad, txData, busy});
    end
    tick();
    checks++;
    if ({grant3, done3, txLoad3, txData3, busy3} !== 18'h0) begin
      failures++;
      $display("FAIL reset_outputs_sb3 act=%h exp=0", {grant3, done3, txLoad3, txData3, busy3});
    end
    req = 4'h0; rstN = 1'b1;
    tick();
    checks++;
    if ({grant, txLoad, busy} !== 6'h0) begin
      failures++;
      $display("FAIL idle_no_req act=%h exp=0", {grant, txLoad, busy});
    end
  endtask

  task automatic test_single();
    req = 4'h0; reqData = 32'h0000_00A5;
    do_reset();
    req = 4'b0001;
    tick();
    checks++;
    if ({txLoad, grant, done, busy, txData} !== {1'b1, 4'b0001, 4'b0000, 1'b1, 8'hA5}) begin
      failures++;
      $display("FAIL single_load act=%h exp=%h", {txLoad, grant, done, busy, txData},
               {1'b1, 4'b0001, 4'b0000, 1'b1, 8'hA5});
    end
    for (int k = 2; k <= 10; k++) begin
      tick();
      checks++;
      if ({txLoad, grant, done, busy, txData} !== {1'b0, 4'b0001, 4'b0000, 1'b1, 8'hA5}) begin
        failures++;
        $display("FAIL single_shift t+%0d act=%h exp=%h", k, {txLoad, grant, done, busy, txData},
                 {1'b0, 4'b0001, 4'b0000, 1'b1, 8'hA5});
      end
    end
    tick();
    checks++;
    if ({txLoad, grant, done, busy} !== {1'b0, 4'b0001, 4'b0001, 1'b1}) begin
      failures++;
      $display("FAIL single_done act=%h exp=%h", {txLoad, grant, done, busy},
               {1'b0, 4'b0001, 4'b0001, 1'b1});
    end
    req = 4'h0;
    tick();
    checks++;
    if ({txLoad, grant, done, busy} !== 10'h0) begin
      failures++;
      $display("FAIL single_idle act=%h exp=0", {txLoad, grant, done, busy});
    end
    tick();
    checks++;
    if ({txLoad, grant, busy} !== 6'h0) begin
      failures++;
      $display("FAIL single_stay_idle act=%h exp=0", {txLoad, grant, busy});
    end
  endtask

  task automatic test_round_robin();
    reqData = 32'hD3C2_B1A0; req = 4'hF;
    do_reset();
    for (int f = 0; f < 5; f++) begin
      logic [3:0] oh;
      logic [7:0] eb;
      oh = 4'b0001 << (f % 4);
      eb = reqData[8*(f%4) +: 8];
      tick();
      checks++;
      if ({txLoad, grant, txData} !== {1'b1, oh, eb}) begin
        failures++;
        $display("FAIL rr_load frame%0d act=%h exp=%h", f, {txLoad, grant, txData}, {1'b1, oh, eb});
      end
      for (int k = 1; k <= 9; k++) begin
        tick();
        checks++;
        if ({txLoad, grant, done, busy} !== {1'b0, oh, 4'b0000, 1'b1}) begin
          failures++;
          $display("FAIL rr_shift frame%0d c%0d act=%h exp=%h", f, k,
                   {txLoad, grant, done, busy}, {1'b0, oh, 4'b0000, 1'b1});
        end
      end
      tick();
      checks++;
      if ({grant, done} !== {oh, oh}) begin
        failures++;
        $display("FAIL rr_done frame%0d act=%h exp=%h", f, {grant, done}, {oh, oh});
      end
      tick();
      checks++;
      if ({grant, done, txLoad, busy} !== 10'h0) begin
        failures++;
        $display("FAIL rr_idle frame%0d act=%h exp=0", f, {grant, done, txLoad, busy});
      end
    end
  endtask

  task automatic test_wrap_skip();
    logic [3:0] exp_g [4];
    logic [3:0] nxt_r [4];
    exp_g = '{4'b0100, 4'b0001, 4'b0100, 4'b1000};
    nxt_r = '{4'b0101, 4'b0101, 4'b1111, 4'b0000};
    reqData = 32'hD3C2_B1A0; req = 4'b0100;
    do_reset();
    for (int f = 0; f < 4; f++) begin
      tick();
      checks++;
      if ({txLoad, grant} !== {1'b1, exp_g[f]}) begin
        failures++;
        $display("FAIL wrap_grant frame%0d act=%h exp=%h", f, {txLoad, grant}, {1'b1, exp_g[f]});
      end
      repeat (10) tick();
      checks++;
      if (done !== exp_g[f]) begin
        failures++;
        $display("FAIL wrap_done frame%0d act=%b exp=%b", f, done, exp_g[f]);
      end
      req = nxt_r[f];
      tick();
    end
  endtask

  task automatic test_drop();
    reqData = 32'hD3C2_B1A0; req = 4'b0001;
    do_reset();
    tick();
    checks++;
    if ({txLoad, grant} !== {1'b1, 4'b0001}) begin
      failures++;
      $display("FAIL drop_load act=%h exp=%h", {txLoad, grant}, {1'b1, 4'b0001});
    end
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 4) req = 4'b0000;
      if (k == 6) req = 4'b1000;
      checks++;
      if ({txLoad, grant, done, busy} !== {1'b0, 4'b0001, 4'b0000, 1'b1}) begin
        failures++;
        $display("FAIL drop_shift c%0d act=%h exp=%h", k, {txLoad, grant, done, busy},
                 {1'b0, 4'b0001, 4'b0000, 1'b1});
      end
    end
    tick();
    checks++;
    if (done !== 4'b0001) begin
      failures++;
      $display("FAIL drop_done act=%b exp=0001", done);
    end
    tick();
    checks++;
    if ({grant, busy} !== 5'h0) begin
      failures++;
      $display("FAIL drop_idle act=%h exp=0", {grant, busy});
    end
    tick();
    checks++;
    if ({txLoad, grant, txData} !== {1'b1, 4'b1000, 8'hD3}) begin
      failures++;
      $display("FAIL drop_next_grant act=%h exp=%h", {txLoad, grant, txData}, {1'b1, 4'b1000, 8'hD3});
    end
  endtask

  task automatic test_mid_reset();
    reqData = 32'hD3C2_B1A0; req = 4'b0110;
    do_reset();
    tick();
    checks++;
    if ({txLoad, grant} !== {1'b1, 4'b0010}) begin
      failures++;
      $display("FAIL mrst_first_grant act=%h exp=%h", {txLoad, grant}, {1'b1, 4'b0010});
    end
    repeat (5) tick();
    rstN = 1'b0;
    #1;
    checks++;
    if ({grant, done, txLoad, txData, busy} !== 18'h0) begin
      failures++;
      $display("FAIL mrst_async act=%h exp=0", {grant, done, txLoad, txData, busy});
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({grant, done, txLoad, busy} !== 10'h0) begin
        failures++;
        $display("FAIL mrst_held c%0d act=%h exp=0", k, {grant, done, txLoad, busy});
      end
    end
    rstN = 1'b1;
    #1;
    checks++;
    if ({txLoad, busy} !== 2'b00) begin
      failures++;
      $display("FAIL mrst_release_idle act=%b exp=00", {txLoad, busy});
    end
    tick();
    checks++;
    if ({txLoad, grant} !== {1'b1, 4'b0010}) begin
      failures++;
      $display("FAIL mrst_regrant act=%h exp=%h", {txLoad, grant}, {1'b1, 4'b0010});
    end
  endtask

  task automatic test_stop3();
    reqData = 32'hD3C2_B1A0; req = 4'b0010;
    do_reset();
    tick();
    checks++;
    if ({txLoad3, grant3, txData3} !== {1'b1, 4'b0010, 8'hB1}) begin
      failures++;
      $display("FAIL sb3_load act=%h exp=%h", {txLoad3, grant3, txData3}, {1'b1, 4'b0010, 8'hB1});
    end
    repeat (9) tick();
    for (int k = 11; k <= 12; k++) begin
      tick();
      checks++;
      if ({txLoad3, grant3, done3, busy3} !== {1'b0, 4'b0010, 4'b0000, 1'b1}) begin
        failures++;
        $display("FAIL sb3_gap t+%0d act=%h exp=%h", k, {txLoad3, grant3, done3, busy3},
                 {1'b0, 4'b0010, 4'b0000, 1'b1});
      end
    end
    tick();
    checks++;
    if ({grant3, done3, busy3} !== {4'b0010, 4'b0010, 1'b1}) begin
      failures++;
      $display("FAIL sb3_done act=%h exp=%h", {grant3, done3, busy3}, {4'b0010, 4'b0010, 1'b1});
    end
    tick();
    checks++;
    if ({txLoad3, grant3, done3, busy3} !== 10'h0) begin
      failures++;
      $display("FAIL sb3_idle act=%h exp=0", {txLoad3, grant3, done3, busy3});
    end
    tick();
    checks++;
    if ({txLoad3, grant3} !== {1'b1, 4'b0010}) begin
      failures++;
      $display("FAIL sb3_next_load act=%h exp=%h", {txLoad3, grant3}, {1'b1, 4'b0010});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_skip();
    test_drop();
    test_mid_reset();
    test_stop3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
